// File: rtl/dfe_mpram_pkg.sv
// Shared types and address-map helpers for the DFE coefficient memory.
package dfe_mpram_pkg;

  typedef enum logic [1:0] {REG_FRAC, REG_IIR, REG_CTRL, REG_CIC} region_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} apb_state_e;

  localparam int unsigned NUM_REGIONS = 4;

  // Word count of one region.
  function automatic int unsigned region_depth(region_e r, int unsigned taps,
                                               int unsigned nd, int unsigned nc,
                                               int unsigned ncic);
    case (r)
      REG_FRAC: return taps;
      REG_IIR:  return nd;
      REG_CTRL: return nc;
      default:  return ncic;
    endcase
  endfunction

  // First word address of one region; regions are packed back to back.
  function automatic int unsigned region_base(region_e r, int unsigned taps,
                                              int unsigned nd, int unsigned nc);
    case (r)
      REG_FRAC: return 0;
      REG_IIR:  return taps;
      REG_CTRL: return taps + nd;
      default:  return taps + nd + nc;
    endcase
  endfunction

  // Highest mapped word address.
  function automatic int unsigned last_addr(int unsigned taps, int unsigned nd,
                                            int unsigned nc, int unsigned ncic);
    return taps + nd + nc + ncic - 1;
  endfunction

endpackage

// File: rtl/mpram_region_bank.sv
// One coefficient region: shadow words written over the bus, an active copy
// driving the datapath, and commit / FREEZE-deferral control.
module mpram_region_bank #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned BASE       = 0,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  freeze_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DATA_WIDTH-1:0] active_o [DEPTH],
  output logic                  vld_o,
  output logic                  pending_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] off;
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
  logic [DATA_WIDTH-1:0] shadow_d [DEPTH];
  logic [DATA_WIDTH-1:0] active_q [DEPTH];
  logic                  trigger;
  logic                  commit;
  logic                  pending_q;
  logic                  pending_d;
  logic                  vld_q;

  // Offset wraps in ADDR_WIDTH arithmetic; the caller only enables writes
  // for addresses inside this region.
  assign off     = addr_i - BASE_A;
  assign trigger = wr_en_i && (off == LAST_OFF);
  // A pending release and a fresh trigger on the same edge merge into one commit.
  assign commit    = !freeze_i && (trigger || pending_q);
  assign pending_d = freeze_i ? (pending_q || trigger) : 1'b0;

  // Shadow next-state: the addressed word takes the write data. The active
  // copy loads from this so the commit includes the triggering word.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    assign shadow_d[gi] = (wr_en_i && (off == ADDR_WIDTH'(gi))) ? wr_data_i : shadow_q[gi];
  end

  // Readback of the shadow word at the current offset.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (off == ADDR_WIDTH'(i)) rd_data_o = shadow_q[i];
    end
  end

  // Shadow storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Active storage, updated only as a whole region.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) active_q[i] <= '0;
    end else if (commit) begin
      active_q <= shadow_d;
    end
  end

  // Deferral flag and one-cycle commit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      vld_q     <= commit;
    end
  end

  assign active_o  = active_q;
  assign vld_o     = vld_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/coeff_bank_mpram.sv
// Double-buffered DFE coefficient memory with an APB-style slave port.
// Every transfer takes one wait state; writes land in the shadow banks.
module coeff_bank_mpram
  import dfe_mpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAPS       = 72,
  parameter int unsigned NUM_DENUM  = 5,
  parameter int unsigned NUM_CTRL   = 6,
  parameter int unsigned NUM_CIC    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  FREEZE,
  output logic [DATA_WIDTH-1:0] FRAC_DECI_OUT [TAPS],
  output logic [DATA_WIDTH-1:0] IIR_OUT [NUM_DENUM],
  output logic [DATA_WIDTH-1:0] CTRL_OUT [NUM_CTRL],
  output logic [DATA_WIDTH-1:0] CIC_R_OUT [NUM_CIC],
  output logic [3:0]            VLD,
  output logic [3:0]            PENDING
);

  localparam int unsigned LAST = last_addr(TAPS, NUM_DENUM, NUM_CTRL, NUM_CIC);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST);

  if ((64'(LAST) >> ADDR_WIDTH) != 0) begin : g_bad_map
    $error("coeff_bank_mpram: address map does not fit in ADDR_WIDTH");
  end

  apb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic                  oor;
  logic                  wr_go;
  logic [NUM_REGIONS-1:0] region_sel;
  logic [NUM_REGIONS-1:0] region_wr;
  logic [DATA_WIDTH-1:0] bank_rd [NUM_REGIONS];
  logic [DATA_WIDTH-1:0] rd_mux;

  assign oor   = addr_q > LAST_A;
  // Storage changes on the edge that ends DONE.
  assign wr_go = (state_q == ST_DONE) && write_q && !oor;

  // Region decode: the wrapped offset is below the depth only inside the
  // region, since the whole map fits in the address space.
  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_dec
    localparam int unsigned RBASE  = region_base(region_e'(gi), TAPS, NUM_DENUM, NUM_CTRL);
    localparam int unsigned RDEPTH = region_depth(region_e'(gi), TAPS, NUM_DENUM, NUM_CTRL, NUM_CIC);
    logic [ADDR_WIDTH-1:0] roff;
    assign roff           = addr_q - ADDR_WIDTH'(RBASE);
    assign region_sel[gi] = roff < ADDR_WIDTH'(RDEPTH);
    assign region_wr[gi]  = wr_go && region_sel[gi];
  end

  // Select the readback word of the addressed region.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (region_sel[i]) rd_mux = bank_rd[i];
    end
  end

  mpram_region_bank #(
    .DEPTH(TAPS), .BASE(region_base(REG_FRAC, TAPS, NUM_DENUM, NUM_CTRL)),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_frac (
    .clk(clk), .rst(rst), .wr_en_i(region_wr[0]), .addr_i(addr_q), .wr_data_i(wdata_q),
    .freeze_i(FREEZE), .rd_data_o(bank_rd[0]), .active_o(FRAC_DECI_OUT),
    .vld_o(VLD[0]), .pending_o(PENDING[0])
  );

  mpram_region_bank #(
    .DEPTH(NUM_DENUM), .BASE(region_base(REG_IIR, TAPS, NUM_DENUM, NUM_CTRL)),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_iir (
    .clk(clk), .rst(rst), .wr_en_i(region_wr[1]), .addr_i(addr_q), .wr_data_i(wdata_q),
    .freeze_i(FREEZE), .rd_data_o(bank_rd[1]), .active_o(IIR_OUT),
    .vld_o(VLD[1]), .pending_o(PENDING[1])
  );

  mpram_region_bank #(
    .DEPTH(NUM_CTRL), .BASE(region_base(REG_CTRL, TAPS, NUM_DENUM, NUM_CTRL)),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_ctrl (
    .clk(clk), .rst(rst), .wr_en_i(region_wr[2]), .addr_i(addr_q), .wr_data_i(wdata_q),
    .freeze_i(FREEZE), .rd_data_o(bank_rd[2]), .active_o(CTRL_OUT),
    .vld_o(VLD[2]), .pending_o(PENDING[2])
  );

  mpram_region_bank #(
    .DEPTH(NUM_CIC), .BASE(region_base(REG_CIC, TAPS, NUM_DENUM, NUM_CTRL)),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_cic (
    .clk(clk), .rst(rst), .wr_en_i(region_wr[3]), .addr_i(addr_q), .wr_data_i(wdata_q),
    .freeze_i(FREEZE), .rd_data_o(bank_rd[3]), .active_o(CIC_R_OUT),
    .vld_o(VLD[3]), .pending_o(PENDING[3])
  );

  // APB transfer FSM: capture the request, wait one state, respond in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (PSEL && PENABLE) begin
            state_q <= ST_WAIT;
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
          end
        end
        ST_WAIT: begin
          state_q   <= ST_DONE;
          pready_q  <= 1'b1;
          pslverr_q <= oor;
          if (oor)           prdata_q <= '0;
          else if (!write_q) prdata_q <= rd_mux;
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_coeff_bank_mpram.sv
// Directed bench for coeff_bank_mpram with hand-computed expectations.
module tb_coeff_bank_mpram;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE, FREEZE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] frac [72];
  logic [31:0] iir [5];
  logic [31:0] ctrl [6];
  logic [31:0] cic [1];
  logic [3:0]  VLD, PENDING;

  int n_cmp = 0;
  int n_bad = 0;

  // Values sampled during the last transfer.
  logic [2:0]  rdy_tr;
  logic        serr_d;
  logic [31:0] rdata_d;
  logic [3:0]  vld_d;

  coeff_bank_mpram dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .FREEZE(FREEZE), .FRAC_DECI_OUT(frac), .IIR_OUT(iir),
    .CTRL_OUT(ctrl), .CIC_R_OUT(cic), .VLD(VLD), .PENDING(PENDING)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer; PSEL/PENABLE held for a single cycle. Returns at the
  // negedge after the edge that ends DONE.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr,
                          input logic [31:0] data, input logic drop_freeze);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(negedge clk);
    rdy_tr[2] = PREADY;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    rdy_tr[1] = PREADY; serr_d = PSLVERR; rdata_d = PRDATA; vld_d = VLD;
    if (drop_freeze) FREEZE = 1'b0;
    @(negedge clk);
    rdy_tr[0] = PREADY;
    $display("xfer %s addr=%0d wdata=0x%0h prdata=0x%0h pslverr=%0b vld=%b pending=%b",
             wr ? "WR" : "RD", addr, data, rdata_d, serr_d, VLD, PENDING);
  endtask

  initial begin
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; FREEZE = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", {31'b0, PREADY}, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_vld", {28'b0, VLD}, 32'h0);
    check("rst_pending", {28'b0, PENDING}, 32'h0);

    // Reset in DONE abandons the write to addr 3.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'd3; PWDATA = 32'h55;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_pready", {31'b0, PREADY}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apb_xfer(1'b0, 8'd3, 32'h0, 1'b0);
    check("midrst_shadow3", rdata_d, 32'h0);
    check("midrst_frac3", frac[3], 32'h0);

    // Atomic commit of the tap region.
    for (int a = 0; a <= 70; a++) apb_xfer(1'b1, 8'(a), 32'h11, 1'b0);
    check("partial_frac0", frac[0], 32'h0);
    check("partial_frac70", frac[70], 32'h0);
    check("partial_vld", {28'b0, VLD}, 32'h0);
    apb_xfer(1'b1, 8'd71, 32'h22, 1'b0);
    check("commit_vld", {28'b0, VLD}, 32'h1);
    check("commit_frac0", frac[0], 32'h11);
    check("commit_frac3", frac[3], 32'h11);
    check("commit_frac71", frac[71], 32'h22);
    @(negedge clk);
    check("commit_vld_drop", {28'b0, VLD}, 32'h0);

    // Handshake timing and readback.
    apb_xfer(1'b1, 8'd72, 32'hDEADBEEF, 1'b0);
    check("wr_ready_trace", {29'b0, rdy_tr}, 32'h2);
    check("wr_iir0_unchanged", iir[0], 32'h0);
    apb_xfer(1'b0, 8'd72, 32'h0, 1'b0);
    check("rd_ready_trace", {29'b0, rdy_tr}, 32'h2);
    check("rd_prdata72", rdata_d, 32'hDEADBEEF);
    check("rd_pslverr72", {31'b0, serr_d}, 32'h0);
    check("rd_prdata_hold", PRDATA, 32'hDEADBEEF);

    // Out-of-range accesses.
    apb_xfer(1'b1, 8'd84, 32'h1234, 1'b0);
    check("oor_wr_pslverr", {31'b0, serr_d}, 32'h1);
    check("oor_wr_ready", {29'b0, rdy_tr}, 32'h2);
    check("oor_wr_vld", {28'b0, VLD}, 32'h0);
    check("oor_wr_cic", cic[0], 32'h0);
    apb_xfer(1'b0, 8'd200, 32'h0, 1'b0);
    check("oor_rd_prdata", rdata_d, 32'h0);
    check("oor_rd_pslverr", {31'b0, serr_d}, 32'h1);
    apb_xfer(1'b0, 8'd83, 32'h0, 1'b0);
    check("oor_no_store83", rdata_d, 32'h0);

    // FREEZE defers IIR and CIC commits.
    FREEZE = 1'b1;
    for (int a = 72; a <= 76; a++) apb_xfer(1'b1, 8'(a), 32'h100 + 32'(a - 72), 1'b0);
    check("frz_pending_iir", {28'b0, PENDING}, 32'h2);
    apb_xfer(1'b1, 8'd83, 32'h8, 1'b0);
    check("frz_pending", {28'b0, PENDING}, 32'hA);
    check("frz_vld", {28'b0, VLD}, 32'h0);
    check("frz_iir0", iir[0], 32'h0);
    check("frz_cic", cic[0], 32'h0);
    FREEZE = 1'b0;
    @(negedge clk);
    check("rel_vld", {28'b0, VLD}, 32'hA);
    check("rel_pending", {28'b0, PENDING}, 32'h0);
    check("rel_iir0", iir[0], 32'h100);
    check("rel_iir4", iir[4], 32'h104);
    check("rel_cic", cic[0], 32'h8);
    check("rel_ctrl0", ctrl[0], 32'h0);
    @(negedge clk);
    check("rel_vld_drop", {28'b0, VLD}, 32'h0);

    // Release and trigger on the same edge merge into one commit.
    FREEZE = 1'b1;
    apb_xfer(1'b1, 8'd83, 32'h9, 1'b0);
    check("sim_pending", {28'b0, PENDING}, 32'h8);
    check("sim_cic_held", cic[0], 32'h8);
    apb_xfer(1'b1, 8'd83, 32'hA, 1'b1);
    check("sim_vld_before", {28'b0, vld_d}, 32'h0);
    check("sim_vld", {28'b0, VLD}, 32'h8);
    check("sim_cic", cic[0], 32'hA);
    check("sim_pending_clr", {28'b0, PENDING}, 32'h0);
    @(negedge clk);
    check("sim_vld_single", {28'b0, VLD}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
